// File: rtl/y86_mem_pkg.sv
// Shared types and constants for the y86 memory arbiter: FSM states, grant encoding and
// the legal wait-state range.
package y86_mem_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      DONE
   } state_e;

   typedef enum logic {
      GNT_CPU,
      GNT_DBG
   } grant_e;

   localparam int unsigned MEM_LAT_MIN = 1;
   localparam int unsigned MEM_LAT_MAX = 15;

   // Out-of-range latencies are clamped so the 4-bit wait counter can never wrap.
   function automatic logic [3:0] mem_lat_load(int unsigned lat);
      if (lat < MEM_LAT_MIN) return 4'(MEM_LAT_MIN);
      if (lat > MEM_LAT_MAX) return 4'(MEM_LAT_MAX);
      return 4'(lat);
   endfunction

endpackage

// File: rtl/y86_mem_arbiter_if.sv
// Bus bundle between the two requesters (core, debug/loader), the arbiter and the memory macro.
// slave = arbiter side; master = requesters plus memory side.
interface y86_mem_arbiter_if #(
   parameter int unsigned AW = 32,
   parameter int unsigned DW = 32
);

   logic          cpu_req;
   logic          cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata;
   logic [DW-1:0] cpu_rdata;
   logic          cpu_done;
   logic          cpu_stall;

   logic          dbg_req;
   logic          dbg_we;
   logic [AW-1:0] dbg_addr;
   logic [DW-1:0] dbg_wdata;
   logic [DW-1:0] dbg_rdata;
   logic          dbg_done;

   logic          mem_re;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_rdata, cpu_done, cpu_stall,
      input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
      output dbg_rdata, dbg_done,
      output mem_re, mem_we, mem_addr, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_rdata, cpu_done, cpu_stall,
      output dbg_req, dbg_we, dbg_addr, dbg_wdata,
      input  dbg_rdata, dbg_done,
      input  mem_re, mem_we, mem_addr, mem_wdata,
      output mem_rdata
   );

endinterface

// File: rtl/y86_rr_arb2.sv
// Combinational two-way round-robin pick: a lone requester wins, a tie goes to whoever
// was not granted last.
module y86_rr_arb2
   import y86_mem_pkg::*;
(
   input  logic   req_cpu,
   input  logic   req_dbg,
   input  grant_e last_grant,
   output grant_e grant,
   output logic   valid
);

   always_comb begin
      grant = GNT_CPU;
      if (req_cpu && req_dbg) begin
         if (last_grant == GNT_CPU) grant = GNT_DBG;
      end else if (req_dbg) begin
         grant = GNT_DBG;
      end
   end

   assign valid = req_cpu | req_dbg;

endmodule

// File: rtl/y86_mem_arbiter.sv
// Shares one single-ported memory between the y86 core and the debug/loader port:
// arbitration, wait-state counting, per-requester done pulse and core stall.
module y86_mem_arbiter
   import y86_mem_pkg::*;
#(
   parameter int unsigned AW      = 32,
   parameter int unsigned DW      = 32,
   parameter int unsigned MEM_LAT = 1
) (
   input logic             clk,
   input logic             rst,
   y86_mem_arbiter_if.slave bus
);

   localparam logic [3:0] LatLoad = mem_lat_load(MEM_LAT);

   state_e        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          we_q, we_d;
   grant_e        gnt_q, gnt_d;
   grant_e        last_q, last_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
   logic [DW-1:0] dbg_rdata_q, dbg_rdata_d;

   grant_e arb_grant;
   logic   arb_valid;
   logic   cpu_done;

   y86_rr_arb2 u_arb (
      .req_cpu    (bus.cpu_req),
      .req_dbg    (bus.dbg_req),
      .last_grant (last_q),
      .grant      (arb_grant),
      .valid      (arb_valid)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      we_d        = we_q;
      gnt_d       = gnt_q;
      last_d      = last_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      cpu_rdata_d = cpu_rdata_q;
      dbg_rdata_d = dbg_rdata_q;

      case (state_q)
         IDLE: begin
            if (arb_valid) begin
               state_d = ACCESS;
               cnt_d   = LatLoad;
               gnt_d   = arb_grant;
               last_d  = arb_grant;
               if (arb_grant == GNT_CPU) begin
                  we_d    = bus.cpu_we;
                  addr_d  = bus.cpu_addr;
                  wdata_d = bus.cpu_wdata;
               end else begin
                  we_d    = bus.dbg_we;
                  addr_d  = bus.dbg_addr;
                  wdata_d = bus.dbg_wdata;
               end
            end
         end
         ACCESS: begin
            // mem_rdata is only valid in the final strobe cycle.
            if (cnt_q <= 4'd1) begin
               state_d = DONE;
               if (!we_q) begin
                  if (gnt_q == GNT_CPU) cpu_rdata_d = bus.mem_rdata;
                  else                  dbg_rdata_d = bus.mem_rdata;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= 4'd0;
         we_q        <= 1'b0;
         gnt_q       <= GNT_CPU;
         last_q      <= GNT_DBG;
         addr_q      <= '0;
         wdata_q     <= '0;
         cpu_rdata_q <= '0;
         dbg_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         we_q        <= we_d;
         gnt_q       <= gnt_d;
         last_q      <= last_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         cpu_rdata_q <= cpu_rdata_d;
         dbg_rdata_q <= dbg_rdata_d;
      end
   end

   assign cpu_done      = (state_q == DONE) && (gnt_q == GNT_CPU);
   assign bus.cpu_done  = cpu_done;
   assign bus.dbg_done  = (state_q == DONE) && (gnt_q == GNT_DBG);
   assign bus.cpu_stall = bus.cpu_req && !cpu_done;
   assign bus.cpu_rdata = cpu_rdata_q;
   assign bus.dbg_rdata = dbg_rdata_q;
   assign bus.mem_re    = (state_q == ACCESS) && !we_q;
   assign bus.mem_we    = (state_q == ACCESS) && we_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_y86_mem_arbiter.sv
// Randomized bench for y86_mem_arbiter against a transaction-timeline model with its own
// memory image; includes directed reset, tie-break and mid-access reset cases.
module tb_y86_mem_arbiter;

   localparam int unsigned LAT = 3;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   y86_mem_arbiter_if #(.AW(32), .DW(32)) bus ();

   y86_mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Memory macro: data valid only in the last strobe cycle, garbage otherwise.
   logic [31:0] mem [64];
   int unsigned run_len = 0;
   always @(posedge clk) begin
      if (bus.mem_we) mem[bus.mem_addr[5:0]] <= bus.mem_wdata;
      run_len <= (bus.mem_re || bus.mem_we) ? run_len + 1 : 0;
   end
   assign bus.mem_rdata = (bus.mem_re && run_len == LAT - 1) ? mem[bus.mem_addr[5:0]]
                                                           : 32'hA5A5_A5A5;

   logic [31:0] exp_mem [64];
   logic [31:0] exp_cpu_rd, exp_dbg_rd;
   bit          last_dbg;
   int          n_checks = 0;
   int          n_err = 0;

   bit          f_we [2];
   logic [31:0] f_ad [2];
   logic [31:0] f_wd [2];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic rand_fields();
      for (int r = 0; r < 2; r++) begin
         f_we[r] = 1'($urandom_range(0, 1));
         f_ad[r] = $urandom_range(0, 15);
         f_wd[r] = $urandom();
      end
   endtask

   task automatic drive_req(input int r, input bit req);
      if (r == 0) bus.cpu_req = req;
      else        bus.dbg_req = req;
   endtask

   task automatic scramble(input int r);
      if (r == 0) begin
         bus.cpu_addr  = $urandom();
         bus.cpu_wdata = $urandom();
      end else begin
         bus.dbg_addr  = $urandom();
         bus.dbg_wdata = $urandom();
      end
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check("idle_re", bus.mem_re, 1'b0);
         check("idle_we", bus.mem_we, 1'b0);
         check("idle_done", {bus.cpu_done, bus.dbg_done}, 2'b00);
         check("idle_stall", bus.cpu_stall, 1'b0);
         @(posedge clk); #1;
      end
   endtask

   // Called and returns at posedge+1. Index 0 = core, 1 = debug.
   task automatic run_round(input bit do_cpu, input bit do_dbg);
      bit   act [2];
      int   start [2];
      int   done_c [2];
      int   first;
      int   second;
      int   last_c;
      logic e_re, e_we, strobing;
      logic [31:0] e_ad, e_wd;
      logic e_cdone, e_ddone;

      act[0] = do_cpu;
      act[1] = do_dbg;
      start[0] = 0; start[1] = 0; done_c[0] = -1; done_c[1] = -1;
      if (do_cpu && do_dbg) first = last_dbg ? 0 : 1;
      else                  first = do_cpu ? 0 : 1;
      second = 1 - first;
      start[first]  = 0;
      done_c[first] = LAT + 1;
      last_c = done_c[first];
      if (act[second]) begin
         start[second]  = LAT + 2;
         done_c[second] = 2 * LAT + 3;
         last_c = done_c[second];
         last_dbg = (second == 1);
      end else begin
         last_dbg = (first == 1);
      end

      bus.cpu_we = f_we[0]; bus.cpu_addr = f_ad[0]; bus.cpu_wdata = f_wd[0];
      bus.dbg_we = f_we[1]; bus.dbg_addr = f_ad[1]; bus.dbg_wdata = f_wd[1];
      bus.cpu_req = do_cpu;
      bus.dbg_req = do_dbg;

      for (int c = 0; c <= last_c; c++) begin
         @(negedge clk);
         e_re = 1'b0; e_we = 1'b0; strobing = 1'b0; e_ad = '0; e_wd = '0;
         e_cdone = 1'b0; e_ddone = 1'b0;
         for (int r = 0; r < 2; r++) begin
            if (act[r] && c >= start[r] + 1 && c <= start[r] + int'(LAT)) begin
               strobing = 1'b1;
               e_re = !f_we[r];
               e_we = f_we[r];
               e_ad = f_ad[r];
               e_wd = f_wd[r];
            end
            if (act[r] && c == done_c[r]) begin
               if (r == 0) e_cdone = 1'b1;
               else        e_ddone = 1'b1;
               if (f_we[r]) exp_mem[f_ad[r][5:0]] = f_wd[r];
               else if (r == 0) exp_cpu_rd = exp_mem[f_ad[r][5:0]];
               else             exp_dbg_rd = exp_mem[f_ad[r][5:0]];
            end
         end
         check("mem_re", bus.mem_re, e_re);
         check("mem_we", bus.mem_we, e_we);
         if (strobing) begin
            check("mem_addr", bus.mem_addr, e_ad);
            check("mem_wdata", bus.mem_wdata, e_wd);
         end
         check("cpu_done", bus.cpu_done, e_cdone);
         check("dbg_done", bus.dbg_done, e_ddone);
         check("cpu_stall", bus.cpu_stall, do_cpu && c < done_c[0]);
         if (e_cdone || e_ddone) begin
            check("cpu_rdata", bus.cpu_rdata, exp_cpu_rd);
            check("dbg_rdata", bus.dbg_rdata, exp_dbg_rd);
         end
         @(posedge clk); #1;
         for (int r = 0; r < 2; r++) begin
            if (act[r] && c == done_c[r]) drive_req(r, 1'b0);
            if (act[r] && c + 1 == start[r] + 1) scramble(r);
         end
      end
   endtask

   // Reset lands while a core read is in its second strobe cycle.
   task automatic reset_mid();
      bus.cpu_we = 1'b0; bus.cpu_addr = 32'd5; bus.cpu_wdata = 32'd0;
      bus.cpu_req = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      check("rmid_strobe_before", bus.mem_re, 1'b1);
      @(posedge clk); #1;
      rst = 1'b0;
      bus.cpu_req = 1'b0;
      last_dbg = 1'b1;
      exp_cpu_rd = '0;
      exp_dbg_rd = '0;
      for (int i = 0; i < int'(LAT) + 1; i++) begin
         @(negedge clk);
         check("rmid_re", bus.mem_re, 1'b0);
         check("rmid_done", {bus.cpu_done, bus.dbg_done}, 2'b00);
         check("rmid_cpu_rdata", bus.cpu_rdata, 32'd0);
         @(posedge clk); #1;
      end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) begin
         mem[i]     = $urandom();
         exp_mem[i] = mem[i];
      end
      mem[16] = 32'hDEAD_BEEF;
      exp_mem[16] = 32'hDEAD_BEEF;
      exp_cpu_rd = '0;
      exp_dbg_rd = '0;
      last_dbg = 1'b1;
      bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
      bus.dbg_req = 1'b0; bus.dbg_we = 1'b0; bus.dbg_addr = '0; bus.dbg_wdata = '0;
      rst = 1'b1;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      check("rst_mem_re", bus.mem_re, 1'b0);
      check("rst_mem_we", bus.mem_we, 1'b0);
      check("rst_done", {bus.cpu_done, bus.dbg_done}, 2'b00);
      check("rst_mem_addr", bus.mem_addr, 32'd0);
      check("rst_mem_wdata", bus.mem_wdata, 32'd0);
      check("rst_cpu_rdata", bus.cpu_rdata, 32'd0);
      check("rst_dbg_rdata", bus.dbg_rdata, 32'd0);
      check("rst_stall", bus.cpu_stall, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;

      rand_fields();
      f_we[0] = 1'b0; f_ad[0] = 32'h10;
      run_round(1'b1, 1'b0);
      check("dir_cpu_read", bus.cpu_rdata, 32'hDEAD_BEEF);

      rand_fields();
      f_we[1] = 1'b1; f_ad[1] = 32'h20; f_wd[1] = 32'h1234_5678;
      run_round(1'b0, 1'b1);
      check("dir_dbg_rd_kept", bus.dbg_rdata, 32'd0);
      check("dir_mem_written", mem[32], 32'h1234_5678);

      for (int i = 0; i < 3; i++) begin
         rand_fields();
         run_round(1'b1, 1'b1);
      end
      idle_cycles(2);

      reset_mid();
      rand_fields();
      f_we[0] = 1'b0; f_we[1] = 1'b0;
      run_round(1'b1, 1'b1);

      for (int i = 0; i < 80; i++) begin
         int k;
         rand_fields();
         k = $urandom_range(0, 3);
         if (k == 0)      run_round(1'b1, 1'b0);
         else if (k == 1) run_round(1'b0, 1'b1);
         else             run_round(1'b1, 1'b1);
         if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 2));
      end

      for (int i = 0; i < 64; i++) begin
         if (mem[i] !== exp_mem[i]) begin
            check("final_mem", mem[i], exp_mem[i]);
         end
      end
      check("final_mem16", mem[16], exp_mem[16]);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
